// File: rtl/fft_size_factorizer.sv
// Factors a mixed-radix FFT length N into exponents of 4, 2, 3 and 5, doing one
// constant-divisor trial per cycle. Lengths of zero, lengths with any other prime factor, and exponent overflow are flagged.
module fft_size_factorizer #(
  parameter int W  = 12,
  parameter int EW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          io_in_valid,
  output logic          io_in_ready,
  input  logic [W-1:0]  io_in_len,
  output logic          io_out_valid,
  input  logic          io_out_ready,
  output logic [EW-1:0] io_out_n4,
  output logic [EW-1:0] io_out_n2,
  output logic [EW-1:0] io_out_n3,
  output logic [EW-1:0] io_out_n5,
  output logic          io_out_err
);

  // state  | meaning
  // IDLE   | waiting for a length; io_in_ready high
  // DIV2   | stripping factors of 2
  // DIV3   | stripping factors of 3
  // DIV5   | stripping factors of 5; result is registered on exit
  // DONE   | result presented until io_out_ready
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIV2 = 3'd1;
  localparam logic [2:0] S_DIV3 = 3'd2;
  localparam logic [2:0] S_DIV5 = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [EW:0]   CNT2_MAX = '1;
  localparam logic [EW-1:0] CNT_MAX  = '1;

  logic [2:0]    state;
  logic [W-1:0]  rem;
  logic [EW:0]   cnt2;
  logic [EW-1:0] cnt3;
  logic [EW-1:0] cnt5;
  logic          ovf;

  logic          rem_one;
  logic [W-1:0]  rem_div3;
  logic [W-1:0]  rem_mod3;
  logic [W-1:0]  rem_div5;
  logic [W-1:0]  rem_mod5;
  logic          hit2;
  logic          hit3;
  logic          hit5;

  assign rem_one  = (rem == W'(1));
  assign rem_div3 = rem / W'(3);
  assign rem_mod3 = rem % W'(3);
  assign rem_div5 = rem / W'(5);
  assign rem_mod5 = rem % W'(5);
  assign hit2     = !rem[0] && !rem_one;
  assign hit3     = (rem_mod3 == '0) && !rem_one;
  assign hit5     = (rem_mod5 == '0) && !rem_one;

  assign io_in_ready  = (state == S_IDLE);
  assign io_out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rem        <= '0;
      cnt2       <= '0;
      cnt3       <= '0;
      cnt5       <= '0;
      ovf        <= 1'b0;
      io_out_n4  <= '0;
      io_out_n2  <= '0;
      io_out_n3  <= '0;
      io_out_n5  <= '0;
      io_out_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io_in_valid) begin
            rem  <= io_in_len;
            cnt2 <= '0;
            cnt3 <= '0;
            cnt5 <= '0;
            ovf  <= 1'b0;
            if (io_in_len == '0) begin
              io_out_n4  <= '0;
              io_out_n2  <= '0;
              io_out_n3  <= '0;
              io_out_n5  <= '0;
              io_out_err <= 1'b1;
              state      <= S_DONE;
            end else begin
              state <= S_DIV2;
            end
          end
        end
        S_DIV2: begin
          if (hit2) begin
            rem <= rem >> 1;
            // Saturated counters keep dividing so the residual check stays meaningful.
            if (cnt2 == CNT2_MAX) ovf <= 1'b1;
            else                  cnt2 <= cnt2 + 1'b1;
          end else begin
            state <= S_DIV3;
          end
        end
        S_DIV3: begin
          if (hit3) begin
            rem <= rem_div3;
            if (cnt3 == CNT_MAX) ovf <= 1'b1;
            else                 cnt3 <= cnt3 + 1'b1;
          end else begin
            state <= S_DIV5;
          end
        end
        S_DIV5: begin
          if (hit5) begin
            rem <= rem_div5;
            if (cnt5 == CNT_MAX) ovf <= 1'b1;
            else                 cnt5 <= cnt5 + 1'b1;
          end else begin
            io_out_n4  <= cnt2[EW:1];
            io_out_n2  <= {{(EW-1){1'b0}}, cnt2[0]};
            io_out_n3  <= cnt3;
            io_out_n5  <= cnt5;
            io_out_err <= !rem_one || ovf;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (io_out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_size_factorizer.sv
// Directed-vector bench for fft_size_factorizer: table of lengths with hand-computed
// exponents and latency, plus backpressure and mid-operation reset sequences.
module tb_fft_size_factorizer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [11:0] io_in_len = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [2:0]  io_out_n4;
  logic [2:0]  io_out_n2;
  logic [2:0]  io_out_n3;
  logic [2:0]  io_out_n5;
  logic        io_out_err;

  int checks = 0;
  int failures = 0;

  fft_size_factorizer #(.W(12), .EW(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_len    (io_in_len),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_n4    (io_out_n4),
    .io_out_n2    (io_out_n2),
    .io_out_n3    (io_out_n3),
    .io_out_n5    (io_out_n5),
    .io_out_err   (io_out_err)
  );

  always #5 clk = ~clk;

  // lat = rising edges after the accept edge until io_out_valid is seen (c2+c3+c5+3).
  // N=0 skips the divide states, so its result is already visible right after the accept edge.
  typedef struct {
    logic [11:0] len;
    logic [2:0]  n4;
    logic [2:0]  n2;
    logic [2:0]  n3;
    logic [2:0]  n5;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_and_wait(input logic [11:0] len, output int lat);
    io_in_len   = len;
    io_in_valid = 1'b1;
    tick();
    io_in_valid = 1'b0;
    io_in_len   = 12'hABC;
    lat = 0;
    while (!io_out_valid && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input vec_t v);
    string tag;
    tag = $sformatf("N=%0d", v.len);
    chk({tag, " valid"}, 32'(io_out_valid), 32'd1);
    chk({tag, " n4"},    32'(io_out_n4),    32'(v.n4));
    chk({tag, " n2"},    32'(io_out_n2),    32'(v.n2));
    chk({tag, " n3"},    32'(io_out_n3),    32'(v.n3));
    chk({tag, " n5"},    32'(io_out_n5),    32'(v.n5));
    chk({tag, " err"},   32'(io_out_err),   32'(v.err));
    chk({tag, " in_ready_busy"}, 32'(io_in_ready), 32'd0);
  endtask

  task automatic consume(input string tag);
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
    chk({tag, " valid_dropped"}, 32'(io_out_valid), 32'd0);
    chk({tag, " in_ready_back"}, 32'(io_in_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    accept_and_wait(v.len, lat);
    chk($sformatf("N=%0d latency", v.len), 32'(lat), 32'(v.lat));
    check_result(v);
    consume($sformatf("N=%0d", v.len));
  endtask

  initial begin
    int lat;
    vec_t v;

    vecs[0]  = '{len: 12'd1,    n4: 3'd0, n2: 3'd0, n3: 3'd0, n5: 3'd0, err: 1'b0, lat: 3};
    vecs[1]  = '{len: 12'd12,   n4: 3'd1, n2: 3'd0, n3: 3'd1, n5: 3'd0, err: 1'b0, lat: 6};
    vecs[2]  = '{len: 12'd1296, n4: 3'd2, n2: 3'd0, n3: 3'd4, n5: 3'd0, err: 1'b0, lat: 11};
    vecs[3]  = '{len: 12'd1200, n4: 3'd2, n2: 3'd0, n3: 3'd1, n5: 3'd2, err: 1'b0, lat: 10};
    vecs[4]  = '{len: 12'd7,    n4: 3'd0, n2: 3'd0, n3: 3'd0, n5: 3'd0, err: 1'b1, lat: 3};
    vecs[5]  = '{len: 12'd0,    n4: 3'd0, n2: 3'd0, n3: 3'd0, n5: 3'd0, err: 1'b1, lat: 0};
    vecs[6]  = '{len: 12'd2048, n4: 3'd5, n2: 3'd1, n3: 3'd0, n5: 3'd0, err: 1'b0, lat: 14};
    vecs[7]  = '{len: 12'd60,   n4: 3'd1, n2: 3'd0, n3: 3'd1, n5: 3'd1, err: 1'b0, lat: 7};
    vecs[8]  = '{len: 12'd4095, n4: 3'd0, n2: 3'd0, n3: 3'd2, n5: 3'd1, err: 1'b1, lat: 6};
    vecs[9]  = '{len: 12'd3125, n4: 3'd0, n2: 3'd0, n3: 3'd0, n5: 3'd5, err: 1'b0, lat: 8};
    vecs[10] = '{len: 12'd2187, n4: 3'd0, n2: 3'd0, n3: 3'd7, n5: 3'd0, err: 1'b0, lat: 10};
    vecs[11] = '{len: 12'd2,    n4: 3'd0, n2: 3'd1, n3: 3'd0, n5: 3'd0, err: 1'b0, lat: 4};
    vecs[12] = '{len: 12'd14,   n4: 3'd0, n2: 3'd1, n3: 3'd0, n5: 3'd0, err: 1'b1, lat: 4};

    #12;
    chk("reset in_ready",  32'(io_in_ready),  32'd1);
    chk("reset out_valid", 32'(io_out_valid), 32'd0);
    chk("reset n4",        32'(io_out_n4),    32'd0);
    chk("reset n3",        32'(io_out_n3),    32'd0);
    chk("reset err",       32'(io_out_err),   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Backpressure: result held, no accept while DONE even with a pending request.
    v = '{len: 12'd24, n4: 3'd1, n2: 3'd1, n3: 3'd1, n5: 3'd0, err: 1'b0, lat: 7};
    accept_and_wait(v.len, lat);
    chk("N=24 latency", 32'(lat), 32'(v.lat));
    io_in_len   = 12'd5;
    io_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_result(v);
      tick();
    end
    io_in_valid = 1'b0;
    consume("N=24");
    chk("N=24 n4 kept", 32'(io_out_n4), 32'd1);
    chk("N=24 n3 kept", 32'(io_out_n3), 32'd1);
    run_vec('{len: 12'd5, n4: 3'd0, n2: 3'd0, n3: 3'd0, n5: 3'd1, err: 1'b0, lat: 4});

    // Reset while in DIV3 of N=1296 (DIV3 spans edges 5..9 after accept).
    io_in_len   = 12'd1296;
    io_in_valid = 1'b1;
    tick();
    io_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("midreset busy", 32'(io_in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(io_out_valid), 32'd0);
    chk("midreset in_ready",  32'(io_in_ready),  32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midreset no_pulse", 32'(io_out_valid), 32'd0);
    end
    run_vec('{len: 12'd60, n4: 3'd1, n2: 3'd0, n3: 3'd1, n5: 3'd1, err: 1'b0, lat: 7});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
